// File: rtl/nv_nvdla_cvif_read_eg_rsp.sv
// CVIF read-response egress: routes AXI R beats to the owning client by thread
// and reports each completed burst back to the read ingress.
//
// state | meaning
// IDLE  | waiting for an R beat; pops the thread's context entry (bubble cycle)
// DATA  | forwarding beats of the current burst until cnt==0 or rlast
module nv_nvdla_cvif_read_eg_rsp #(
  parameter int          DW          = 64,
  parameter logic [15:0] CLIENT_MASK = 16'h03EE
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          noc2cvif_axi_r_rvalid,
  output logic          noc2cvif_axi_r_rready,
  input  logic [7:0]    noc2cvif_axi_r_rid,
  input  logic          noc2cvif_axi_r_rlast,
  input  logic [DW-1:0] noc2cvif_axi_r_rdata,
  output logic [3:0]    cq_rd_thread_id,
  input  logic          cq_rd_pvld,
  output logic          cq_rd_prdy,
  input  logic [6:0]    cq_rd_pd,
  output logic [15:0]   rsp_valid,
  input  logic [15:0]   rsp_ready,
  output logic [DW-1:0] rsp_pd,
  output logic          eg2ig_axi_vld,
  output logic          eg_err_id,
  output logic          eg_err_len,
  input  logic          eg_err_clr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DATA = 1'b1;

  logic [0:0]    state;
  logic [3:0]    cnt;
  logic [3:0]    thr;
  logic          drop;
  logic          out_vld;
  logic [3:0]    thr_q;
  logic [DW-1:0] out_pd;

  logic pop;
  logic new_drop;
  logic out_drain;
  logic beat_acc;
  logic cnt_done;
  logic burst_end;
  logic unused_pd;

  assign unused_pd       = ^cq_rd_pd[6:4];
  assign cq_rd_thread_id = noc2cvif_axi_r_rid[3:0];
  assign new_drop        = !CLIENT_MASK[noc2cvif_axi_r_rid[3:0]] ||
                           (noc2cvif_axi_r_rid[7:4] != 4'h0);
  assign pop             = (state == IDLE) && noc2cvif_axi_r_rvalid && cq_rd_pvld;
  assign cq_rd_prdy      = pop;

  // Ready is judged against the thread actually held in the register, so a
  // beat is never accepted while an undrained beat of another thread sits there.
  assign out_drain             = out_vld && rsp_ready[thr_q];
  assign noc2cvif_axi_r_rready = (state == DATA) && (drop || !out_vld || rsp_ready[thr_q]);
  assign beat_acc              = noc2cvif_axi_r_rvalid && noc2cvif_axi_r_rready;
  assign cnt_done              = (cnt == 4'd0);
  assign burst_end             = beat_acc && (cnt_done || noc2cvif_axi_r_rlast);

  assign rsp_valid = out_vld ? (16'h0001 << thr_q) : 16'h0000;
  assign rsp_pd    = out_pd;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      thr           <= 4'd0;
      drop          <= 1'b0;
      out_vld       <= 1'b0;
      thr_q         <= 4'd0;
      out_pd        <= '0;
      eg2ig_axi_vld <= 1'b0;
      eg_err_id     <= 1'b0;
      eg_err_len    <= 1'b0;
    end else begin
      eg2ig_axi_vld <= burst_end;

      if (state == IDLE) begin
        if (pop) begin
          cnt   <= cq_rd_pd[3:0];
          drop  <= new_drop;
          thr   <= noc2cvif_axi_r_rid[3:0];
          state <= DATA;
        end
      end else begin
        if (beat_acc) begin
          if (cnt_done || noc2cvif_axi_r_rlast) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      end

      // Load wins over drain: a same-cycle drain+load simply replaces the beat.
      if (beat_acc && !drop) begin
        out_vld <= 1'b1;
        out_pd  <= noc2cvif_axi_r_rdata;
        thr_q   <= thr;
      end else if (out_drain) begin
        out_vld <= 1'b0;
      end

      if (pop && new_drop) begin
        eg_err_id <= 1'b1;
      end else if (eg_err_clr) begin
        eg_err_id <= 1'b0;
      end

      if (burst_end && (cnt_done != noc2cvif_axi_r_rlast)) begin
        eg_err_len <= 1'b1;
      end else if (eg_err_clr) begin
        eg_err_len <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cvif_read_eg_rsp.sv
// Bench for the CVIF read-response egress: directed scenarios plus randomized
// bursts scored against a burst-level model of expected client deliveries.
module tb_nv_nvdla_cvif_read_eg_rsp;

  logic        clk;
  logic        rstn;
  logic        rvalid;
  logic        rready;
  logic [7:0]  rid;
  logic        rlast;
  logic [63:0] rdata;
  logic [3:0]  thread_id;
  logic        pvld;
  logic        prdy;
  logic [6:0]  cq_pd;
  logic [15:0] rsp_valid;
  logic [15:0] rsp_ready;
  logic [63:0] rsp_pd;
  logic        eg2ig;
  logic        err_id;
  logic        err_len;
  logic        err_clr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [67:0] got_q[$];
  logic [67:0] exp_q[$];
  int          got_c[$];
  int          pulse_q[$];
  int          exp_pulse[$];
  bit          exp_id;
  bit          exp_len;

  nv_nvdla_cvif_read_eg_rsp #(.DW(64), .CLIENT_MASK(16'h03EE)) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rstn),
    .noc2cvif_axi_r_rvalid (rvalid),
    .noc2cvif_axi_r_rready (rready),
    .noc2cvif_axi_r_rid    (rid),
    .noc2cvif_axi_r_rlast  (rlast),
    .noc2cvif_axi_r_rdata  (rdata),
    .cq_rd_thread_id       (thread_id),
    .cq_rd_pvld            (pvld),
    .cq_rd_prdy            (prdy),
    .cq_rd_pd              (cq_pd),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_pd                (rsp_pd),
    .eg2ig_axi_vld         (eg2ig),
    .eg_err_id             (err_id),
    .eg_err_len            (err_len),
    .eg_err_clr            (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic bit valid_thr(input logic [3:0] t);
    return t inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  endfunction

  function automatic logic [3:0] thr_of(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  function automatic logic [15:0] rand_ready(input logic [3:0] t);
    logic [15:0] r;
    r    = 16'($urandom);
    r[t] = ($urandom_range(0, 9) < 7);
    return r;
  endfunction

  // Client-side monitor: records every handshake and every completion pulse.
  always @(negedge clk) begin
    if (rstn) begin
      if (rsp_valid != 16'h0) begin
        tests++;
        if ($countones(rsp_valid) != 1) begin
          fails++;
          $display("FAIL rsp_valid_onehot: got %h, need exactly one bit", rsp_valid);
        end
      end
      if ((rsp_valid & rsp_ready) != 16'h0) begin
        got_q.push_back({thr_of(rsp_valid & rsp_ready), rsp_pd});
        got_c.push_back(cyc);
      end
      if (eg2ig) pulse_q.push_back(cyc);
      if (prdy) begin
        tests++;
        if (!pvld) begin
          fails++;
          $display("FAIL prdy_without_pvld: prdy=1 pvld=%b", pvld);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rvalid    = 1'b0;
    rlast     = 1'b0;
    pvld      = 1'b0;
    rsp_ready = '1;
    repeat (4) step();
  endtask

  task automatic send_burst(input logic [7:0] id, input logic [3:0] len, input int nb,
                            input bit lastf, input bit rnd, input int stall_at,
                            input int stall_n, output int pop_c, output int first_c,
                            output int last_c);
    int k, guard, stall_left;
    bit drp, in_stall, acc;
    drp        = !valid_thr(id[3:0]) || (id[7:4] != 4'h0);
    pop_c      = -1;
    first_c    = -1;
    last_c     = -1;
    k          = 0;
    guard      = 0;
    stall_left = 0;
    in_stall   = 1'b0;
    rid        = id;
    cq_pd      = {3'($urandom), len};
    rdata      = {$urandom, $urandom};
    rlast      = lastf && (nb == 1);
    rvalid     = 1'b1;
    pvld       = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
    rsp_ready  = rnd ? rand_ready(id[3:0]) : '1;
    forever begin
      @(negedge clk);
      tests++;
      if (rready !== 1'b0) begin
        fails++;
        $display("FAIL rready_idle: got %b, need 0", rready);
      end
      tests++;
      if (prdy !== pvld) begin
        fails++;
        $display("FAIL prdy_idle: got %b, need %b", prdy, pvld);
      end
      if (prdy) break;
      guard++;
      if (guard > 20) begin
        fails++;
        $display("FAIL pop_timeout: no cq pop within 20 cycles for rid %h", id);
        rvalid = 1'b0;
        pvld   = 1'b0;
        return;
      end
      step();
      pvld = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
    pop_c = cyc;
    step();
    pvld  = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
    cq_pd = 7'($urandom);
    guard = 0;
    while (k < nb) begin
      @(negedge clk);
      tests++;
      if (prdy !== 1'b0) begin
        fails++;
        $display("FAIL prdy_in_data: got %b, need 0", prdy);
      end
      if (guard == 0 && drp) begin
        tests++;
        if (err_id !== 1'b1) begin
          fails++;
          $display("FAIL err_id_set: got %b, need 1 for rid %h", err_id, id);
        end
      end
      if (in_stall && !drp) begin
        tests++;
        if (rready !== 1'b0) begin
          fails++;
          $display("FAIL rready_stall: got %b, need 0", rready);
        end
      end
      acc = rvalid && rready;
      if (acc) begin
        if (!drp) exp_q.push_back({id[3:0], rdata});
        if (k == 0) first_c = cyc;
        last_c = cyc;
        k++;
        if (k == stall_at) stall_left = stall_n;
      end
      guard++;
      if (guard > 200) begin
        fails++;
        $display("FAIL beat_timeout: %0d of %0d beats accepted for rid %h", k, nb, id);
        break;
      end
      step();
      if (acc) begin
        rdata  = {$urandom, $urandom};
        rlast  = lastf && (k == nb - 1);
        rvalid = (k < nb) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      end else if (!rvalid) begin
        rvalid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (stall_left > 0) begin
        rsp_ready         = '1;
        rsp_ready[id[3:0]] = 1'b0;
        stall_left--;
        in_stall = 1'b1;
      end else begin
        in_stall  = 1'b0;
        rsp_ready = rnd ? rand_ready(id[3:0]) : '1;
      end
      if (rnd) pvld = ($urandom_range(0, 1) == 1);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    pvld   = 1'b0;
    exp_pulse.push_back(last_c + 1);
    exp_id  = exp_id | drp;
    exp_len = exp_len | (nb != int'(len) + 1) | !lastf;
  endtask

  task automatic check_sb(input string name);
    logic [67:0] e, g;
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_beat_count: got %0d, need %0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s_beat: got thr %0d data %h, need thr %0d data %h",
                 name, g[67:64], g[63:0], e[67:64], e[63:0]);
      end
    end
    tests++;
    if (pulse_q.size() != exp_pulse.size()) begin
      fails++;
      $display("FAIL %s_pulse_count: got %0d, need %0d", name, pulse_q.size(), exp_pulse.size());
    end
    while (exp_pulse.size() > 0 && pulse_q.size() > 0) begin
      int ep, gp;
      ep = exp_pulse.pop_front();
      gp = pulse_q.pop_front();
      tests++;
      if (gp != ep) begin
        fails++;
        $display("FAIL %s_pulse_cycle: got %0d, need %0d", name, gp, ep);
      end
    end
    tests++;
    if (err_id !== exp_id) begin
      fails++;
      $display("FAIL %s_err_id: got %b, need %b", name, err_id, exp_id);
    end
    tests++;
    if (err_len !== exp_len) begin
      fails++;
      $display("FAIL %s_err_len: got %b, need %b", name, err_len, exp_len);
    end
    got_q.delete();
    got_c.delete();
    exp_q.delete();
    pulse_q.delete();
    exp_pulse.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    tests++;
    if ({rready, prdy, rsp_valid, rsp_pd, eg2ig, err_id, err_len} !== '0) begin
      fails++;
      $display("FAIL %s: rready=%b prdy=%b rsp_valid=%h rsp_pd=%h eg2ig=%b err_id=%b err_len=%b, need all 0",
               name, rready, prdy, rsp_valid, rsp_pd, eg2ig, err_id, err_len);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; rvalid = 1'b0; rid = 8'h0; rlast = 1'b0; rdata = '0;
    pvld = 1'b0; cq_pd = '0; rsp_ready = '1; err_clr = 1'b0;
    exp_id = 1'b0; exp_len = 1'b0;
    repeat (3) step();
    check_idle_outputs("reset_values");
    step();
    rstn = 1'b1;
    check_idle_outputs("post_reset_idle");
    step();
  endtask

  task automatic test_single_beat();
    int p, f, l;
    send_burst(8'h01, 4'd0, 1, 1'b1, 1'b0, 0, 0, p, f, l);
    drain();
    tests++;
    if (f != p + 1) begin fails++; $display("FAIL single_accept_cycle: got %0d, need %0d", f, p + 1); end
    tests++;
    if (got_c.size() < 1 || got_c[0] != f + 1) begin
      fails++;
      $display("FAIL single_rsp_latency: got %0d, need %0d", got_c.size() ? got_c[0] : -1, f + 1);
    end
    check_sb("single");
  endtask

  task automatic test_four_beat();
    int p, f, l;
    send_burst(8'h08, 4'd3, 4, 1'b1, 1'b0, 0, 0, p, f, l);
    drain();
    tests++;
    if (l != f + 3) begin fails++; $display("FAIL four_throughput: last %0d, need %0d", l, f + 3); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_c.size() <= i || got_c[i] != f + 1 + i) begin
        fails++;
        $display("FAIL four_rsp_cycle%0d: got %0d, need %0d", i, got_c.size() > i ? got_c[i] : -1, f + 1 + i);
      end
    end
    check_sb("four");
  endtask

  task automatic test_backpressure();
    int p, f, l;
    send_burst(8'h08, 4'd3, 4, 1'b1, 1'b0, 2, 3, p, f, l);
    drain();
    tests++;
    if (l - f + 1 != 7) begin fails++; $display("FAIL bp_total_cycles: got %0d, need 7", l - f + 1); end
    check_sb("backpressure");
  endtask

  task automatic test_back_to_back();
    int p1, f1, l1, p2, f2, l2;
    send_burst(8'h01, 4'd1, 2, 1'b1, 1'b0, 0, 0, p1, f1, l1);
    send_burst(8'h09, 4'd2, 3, 1'b1, 1'b0, 0, 0, p2, f2, l2);
    drain();
    tests++;
    if (p2 != l1 + 1) begin fails++; $display("FAIL b2b_pop_cycle: got %0d, need %0d", p2, l1 + 1); end
    tests++;
    if (f2 != p2 + 1) begin fails++; $display("FAIL b2b_first_beat: got %0d, need %0d", f2, p2 + 1); end
    check_sb("back_to_back");
  endtask

  task automatic test_drop();
    int p, f, l;
    send_burst(8'h04, 4'd1, 2, 1'b1, 1'b0, 0, 0, p, f, l);
    drain();
    check_sb("drop");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (err_id !== 1'b0) begin fails++; $display("FAIL drop_err_clr: got %b, need 0", err_id); end
    exp_id = 1'b0;
    step();
  endtask

  task automatic test_len_error();
    int p, f, l;
    send_burst(8'h02, 4'd3, 2, 1'b1, 1'b0, 0, 0, p, f, l);
    send_burst(8'h03, 4'd0, 1, 1'b0, 1'b0, 0, 0, p, f, l);
    drain();
    check_sb("len_error");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_id = 1'b0; exp_len = 1'b0;
    step();
  endtask

  task automatic test_set_priority();
    int p, f, l;
    err_clr = 1'b1;
    send_burst(8'h15, 4'd0, 1, 1'b1, 1'b0, 0, 0, p, f, l);
    send_burst(8'h02, 4'd3, 2, 1'b1, 1'b0, 0, 0, p, f, l);
    @(negedge clk);
    tests++;
    if (err_len !== 1'b1) begin fails++; $display("FAIL prio_err_len_set: got %b, need 1", err_len); end
    step();
    @(negedge clk);
    tests++;
    if ({err_id, err_len} !== 2'b00) begin
      fails++;
      $display("FAIL prio_clear: got id=%b len=%b, need 0 0", err_id, err_len);
    end
    err_clr = 1'b0;
    exp_id = 1'b0; exp_len = 1'b0;
    drain();
    check_sb("priority");
  endtask

  task automatic test_reset_mid_burst();
    int p, f, l;
    rid = 8'h08; cq_pd = 7'd3; rvalid = 1'b1; rdata = {$urandom, $urandom};
    rlast = 1'b0; pvld = 1'b1; rsp_ready = '1;
    @(negedge clk);
    step();
    pvld = 1'b0;
    @(negedge clk);
    tests++;
    if (rready !== 1'b1) begin fails++; $display("FAIL rst_first_beat_ready: got %b, need 1", rready); end
    step();
    rstn = 1'b0;
    rvalid = 1'b0;
    step();
    check_idle_outputs("reset_mid_burst");
    rstn = 1'b1;
    got_q.delete(); got_c.delete(); exp_q.delete(); pulse_q.delete(); exp_pulse.delete();
    exp_id = 1'b0; exp_len = 1'b0;
    step();
    send_burst(8'h08, 4'd3, 4, 1'b1, 1'b0, 0, 0, p, f, l);
    drain();
    check_sb("after_reset");
  endtask

  task automatic test_random();
    int p, f, l, len, nb, mode;
    logic [3:0] t, hi;
    bit lastf;
    for (int b = 0; b < 40; b++) begin
      t    = 4'($urandom_range(0, 15));
      hi   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      len  = $urandom_range(0, 7);
      mode = $urandom_range(0, 7);
      if (mode == 6 && len > 0) begin
        nb = $urandom_range(1, len); lastf = 1'b1;
      end else if (mode == 7) begin
        nb = len + 1; lastf = 1'b0;
      end else begin
        nb = len + 1; lastf = 1'b1;
      end
      send_burst({hi, t}, 4'(len), nb, lastf, 1'b1, 0, 0, p, f, l);
    end
    drain();
    check_sb("random");
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_four_beat();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_len_error();
    test_set_priority();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
